// File: rtl/dso_cap_pkg.sv
// ---------------------------------------------------------------------------
// dso_cap_pkg
// Shared types and constants for the DSO capture controller.
//   cap_state_e : acquisition FSM states
//   LANES/SAMPLE_W/WORD_W : packed sample word geometry (lane0 is the MSB lane)
//   lane0()     : extracts lane0 from a packed word
// ---------------------------------------------------------------------------
package dso_cap_pkg;

  localparam int LANES    = 16;
  localparam int SAMPLE_W = 8;
  localparam int WORD_W   = LANES * SAMPLE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_WAIT_TRIG,
    ST_POSTTRIG,
    ST_DONE
  } cap_state_e;

  function automatic logic [SAMPLE_W-1:0] lane0(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/dso_capture_ram.sv
// ---------------------------------------------------------------------------
// dso_capture_ram
// Simple dual-port DEPTH x WORD_W ring-buffer storage.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_re/i_raddr      : read request, address
//   o_rdata           : registered read data, valid one cycle after i_re
// ---------------------------------------------------------------------------
module dso_capture_ram
  import dso_cap_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the small
  // output register is reset, keeping the read port at 0 out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dso_capture_ctrl.sv
// ---------------------------------------------------------------------------
// dso_capture_ctrl
// Captures a pre/post-trigger window of 128-bit sample words into a ring
// buffer and plays it back oldest-first on a 1-cycle-latency read port.
// Optional feature macro: DSO_SELF_TRIG_EN (adds trig_level, lane0 > level
// self-trigger ORed with trigin, one cycle behind the external path).
// Ports:
//   clkin, rst_n        : clock, async active-low reset
//   datain, trigin      : sample word, external trigger level
//   arm, abort          : start acquisition, force IDLE
//   pre_len, post_len   : window lengths in words (latched on arm)
//   rd_req              : read one word per asserted cycle in DONE
//   rd_data/rd_valid/rd_last : readout word, its strobe, final-word flag
//   busy, triggered, done    : status
// ---------------------------------------------------------------------------
module dso_capture_ctrl
  import dso_cap_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   datain,
  input  logic                trigin,
`ifdef DSO_SELF_TRIG_EN
  input  logic [SAMPLE_W-1:0] trig_level,
`endif
  input  logic                arm,
  input  logic                abort,
  input  logic [AW:0]         pre_len,
  input  logic [AW:0]         post_len,
  input  logic                rd_req,
  output logic [WORD_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                busy,
  output logic                triggered,
  output logic                done
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  cap_state_e    r_state, w_next_state;
  logic          r_trig_d;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_trig_addr;
  logic [AW:0]   r_cnt, r_rd_cnt, r_pre_len, r_post_len;
  logic          r_triggered, r_rd_valid, r_rd_last;

  logic [AW:0]   w_post_eff, w_pre_max, w_pre_eff, w_total;
  logic          w_trig_src, w_edge, w_rd_is_last;
  logic          w_arm_go, w_wr_en, w_trig_fire, w_enter_done, w_rd_fire;
  logic [AW-1:0] w_rd_start;

  // ---------------- trigger source and edge detect ----------------
`ifdef DSO_SELF_TRIG_EN
  logic r_self_trig;
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) r_self_trig <= 1'b0;
    else        r_self_trig <= (lane0(datain) > trig_level);
  end
  assign w_trig_src = trigin | r_self_trig;
`else
  assign w_trig_src = trigin;
`endif

  // History runs in every state, so a level already high on entry to
  // WAIT_TRIG never looks like an edge.
  assign w_edge = w_trig_src & ~r_trig_d;

  // ---------------- window length clamping (applied at arm) ----------------
  always_comb begin
    w_post_eff = post_len;
    if (post_len == '0)          w_post_eff = ONE_W;
    else if (post_len > DEPTH_W) w_post_eff = DEPTH_W;
    w_pre_max = DEPTH_W - w_post_eff;
    w_pre_eff = (pre_len > w_pre_max) ? w_pre_max : pre_len;
  end

  assign w_total      = r_pre_len + r_post_len;
  assign w_rd_is_last = ((r_rd_cnt + ONE_W) == w_total);
  // Oldest word of the window; when post_len==1 the trigger address is the
  // write pointer of the current cycle, not yet held in r_trig_addr.
  assign w_rd_start   = (w_trig_fire ? r_wr_ptr : r_trig_addr) - r_pre_len[AW-1:0];

  // ---------------- FSM next-state and control strobes ----------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_arm_go     = 1'b0;
    w_wr_en      = 1'b0;
    w_trig_fire  = 1'b0;
    w_enter_done = 1'b0;
    w_rd_fire    = 1'b0;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            w_arm_go     = 1'b1;
            w_next_state = (w_pre_eff == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
          end
        end
        ST_PRETRIG: begin
          w_wr_en = 1'b1;
          if ((r_cnt + ONE_W) == r_pre_len) w_next_state = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          w_wr_en = 1'b1;
          if (w_edge) begin
            w_trig_fire = 1'b1;
            if (r_post_len == ONE_W) begin
              w_enter_done = 1'b1;
              w_next_state = ST_DONE;
            end else begin
              w_next_state = ST_POSTTRIG;
            end
          end
        end
        ST_POSTTRIG: begin
          w_wr_en = 1'b1;
          if ((r_cnt + ONE_W) == r_post_len) begin
            w_enter_done = 1'b1;
            w_next_state = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_req) begin
            w_rd_fire = 1'b1;
            if (w_rd_is_last) w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------- datapath registers ----------------
  // Later assignments deliberately override earlier ones (e.g. the trigger
  // cycle reloads the counter to 1 instead of incrementing it).
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_d    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_rd_cnt    <= '0;
      r_pre_len   <= '0;
      r_post_len  <= '0;
      r_triggered <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_trig_d   <= w_trig_src;
      r_rd_valid <= w_rd_fire;
      r_rd_last  <= w_rd_fire & w_rd_is_last;
      if (abort) r_triggered <= 1'b0;
      if (w_arm_go) begin
        r_pre_len   <= w_pre_eff;
        r_post_len  <= w_post_eff;
        r_wr_ptr    <= '0;
        r_cnt       <= '0;
        r_triggered <= 1'b0;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ONE_A;
        r_cnt    <= r_cnt + ONE_W;
      end
      if (w_trig_fire) begin
        r_trig_addr <= r_wr_ptr;
        r_triggered <= 1'b1;
        r_cnt       <= ONE_W;
      end
      if (w_enter_done) begin
        r_rd_ptr <= w_rd_start;
        r_rd_cnt <= '0;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + ONE_A;
        r_rd_cnt <= r_rd_cnt + ONE_W;
      end
    end
  end

  // ---------------- storage ----------------
  dso_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clkin),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (datain),
    .i_re    (w_rd_fire),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  // ---------------- status outputs ----------------
  assign busy      = (r_state == ST_PRETRIG) || (r_state == ST_WAIT_TRIG) ||
                     (r_state == ST_POSTTRIG);
  assign done      = (r_state == ST_DONE);
  assign triggered = r_triggered;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dso_capture_ctrl
// Self-checking bench for dso_capture_ctrl: a table of capture windows
// (including length clamping and buffer wrap) plus hand-written sequences
// for the ramp/trigger, held-trigger, abort, async reset and (when
// DSO_SELF_TRIG_EN is defined) the self-trigger cases.
// ---------------------------------------------------------------------------
module tb_dso_capture_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clkin;
  logic          rst_n;
  logic [127:0]  datain;
  logic          trigin;
`ifdef DSO_SELF_TRIG_EN
  logic [7:0]    trig_level;
`endif
  logic          arm;
  logic          abort;
  logic [AW:0]   pre_len;
  logic [AW:0]   post_len;
  logic          rd_req;
  logic [127:0]  rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          triggered;
  logic          done;

  dso_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .datain    (datain),
    .trigin    (trigin),
`ifdef DSO_SELF_TRIG_EN
    .trig_level(trig_level),
`endif
    .arm       (arm),
    .abort     (abort),
    .pre_len   (pre_len),
    .post_len  (post_len),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy),
    .triggered (triggered),
    .done      (done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Capture windows: source word = sample index, trigger level rises at
  // index trig. Arm is at index 0, so PRETRIG stores indices 1..pre.
  typedef struct {
    int pre;
    int post;
    int trig;
    int exp_first;
    int exp_count;
  } cap_vec_t;

  cap_vec_t vecs [7];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int      idx, v, nval, nerr;
    bit      got_last;
    logic [127:0] last_word;

    vecs[0] = '{pre: 4,         post: 8,    trig: 20,   exp_first: 16, exp_count: 12};
    vecs[1] = '{pre: 0,         post: 0,    trig: 5,    exp_first: 5,  exp_count: 1};
    vecs[2] = '{pre: 0,         post: 1,    trig: 3,    exp_first: 3,  exp_count: 1};
    // pre clamped to DEPTH-8 = 1016; window spans the full buffer across wrap
    vecs[3] = '{pre: DEPTH-2,   post: 8,    trig: 1100, exp_first: 84, exp_count: 1024};
    // post clamped to DEPTH, pre forced to 0
    vecs[4] = '{pre: 5,         post: 2000, trig: 10,   exp_first: 10, exp_count: 1024};
    vecs[5] = '{pre: 3,         post: 1,    trig: 10,   exp_first: 7,  exp_count: 4};
    vecs[6] = '{pre: DEPTH-1,   post: 1,    trig: 1030, exp_first: 7,  exp_count: 1024};

    rst_n = 1'b0; datain = '0; trigin = 1'b0; arm = 1'b0; abort = 1'b0;
    pre_len = '0; post_len = '0; rd_req = 1'b0;
`ifdef DSO_SELF_TRIG_EN
    trig_level = 8'd200;
`endif
    #12;
    check("reset_busy",      busy,      1'b0);
    check("reset_done",      done,      1'b0);
    check("reset_triggered", triggered, 1'b0);
    check("reset_rd_valid",  rd_valid,  1'b0);
    check("reset_rd_last",   rd_last,   1'b0);
    check("reset_rd_data",   rd_data,   128'h0);
    #11 rst_n = 1'b1;
    step();

    // ---------------- table-driven capture windows ----------------
    for (int r = 0; r < 7; r++) begin
      datain = '0; trigin = 1'b0;
      pre_len  = (AW+1)'(vecs[r].pre);
      post_len = (AW+1)'(vecs[r].post);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("tbl_arm_busy", busy, 1'b1);
      check("tbl_arm_clears_triggered", triggered, 1'b0);
      idx = 1;
      while (!done && idx < vecs[r].trig + vecs[r].exp_count + 20) begin
        datain = 128'(idx);
        trigin = (idx >= vecs[r].trig);
        step();
        idx++;
      end
      check("tbl_done", done, 1'b1);
      check("tbl_triggered_at_done", triggered, 1'b1);
      nval = 0; nerr = 0; got_last = 1'b0; last_word = '0;
      rd_req = 1'b1;
      for (int c = 0; c < vecs[r].exp_count + 5 && !got_last; c++) begin
        step();
        if (rd_valid) begin
          if (rd_data !== 128'(vecs[r].exp_first + nval)) nerr++;
          last_word = rd_data;
          nval++;
          if (rd_last) got_last = 1'b1;
        end
      end
      rd_req = 1'b0;
      check("tbl_rd_last_seen", got_last, 1'b1);
      check("tbl_word_count", nval, vecs[r].exp_count);
      check("tbl_order_errors", nerr, 0);
      check("tbl_last_word", last_word, 128'(vecs[r].exp_first + vecs[r].exp_count - 1));
      check("tbl_done_clear_after_read", done, 1'b0);
      check("tbl_triggered_kept_after_read", triggered, 1'b1);
      step();
    end

    // ---------------- ramp 10..246 with lane trigger at >118 ----------------
    pre_len = 11'd4; post_len = 11'd8;
    datain = {16{8'd10}}; trigin = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0;
    v = 11;
    while (!done && v <= 246) begin
      datain = {16{8'(v)}};
      trigin = (v > 118);
      step();
      v++;
    end
    check("ramp_done", done, 1'b1);
    rd_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("ramp_rd_valid", rd_valid, 1'b1);
      check("ramp_word", rd_data, {16{8'(115 + k)}});
      check("ramp_rd_last", rd_last, (k == 11));
    end
    rd_req = 1'b0;
    step();
    check("ramp_rd_valid_after_last", rd_valid, 1'b0);
    check("ramp_idle_after_read", done, 1'b0);

    // ---------------- trigger held high across arm ----------------
    trigin = 1'b1; datain = '0;
    step(); step(); step();
    pre_len = 11'd0; post_len = 11'd4; arm = 1'b1;
    step();
    arm = 1'b0;
    check("held_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      datain = 128'(100 + i);
      step();
    end
    check("held_no_trigger", triggered, 1'b0);
    check("held_not_done", done, 1'b0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("held_rd_req_ignored", rd_valid, 1'b0);
    trigin = 1'b0; datain = 128'(300);
    step();
    trigin = 1'b1; datain = 128'(500);
    step();
    check("held_retrigger", triggered, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      datain = 128'(500 + i);
      step();
    end
    check("held_done", done, 1'b1);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("held_rd_valid", rd_valid, 1'b1);
    check("held_trigger_word", rd_data, 128'(500));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("done_abort_done", done, 1'b0);
    check("done_abort_triggered", triggered, 1'b0);
    check("done_abort_rd_valid", rd_valid, 1'b0);

    // ---------------- abort together with trigger edge ----------------
    trigin = 1'b0; pre_len = 11'd2; post_len = 11'd4; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      datain = 128'(700 + i);
      step();
    end
    check("abort_pre_busy", busy, 1'b1);
    trigin = 1'b1; abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_triggered", triggered, 1'b0);
    check("abort_done", done, 1'b0);
    trigin = 1'b0;
    step();
    trigin = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("abort_stays_idle", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    check("abort_no_trigger", triggered, 1'b0);

    // ---------------- async reset mid-POSTTRIG ----------------
    trigin = 1'b0; pre_len = 11'd0; post_len = 11'd8; arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    trigin = 1'b1;
    step();
    step(); step();
    check("rst_pre_busy", busy, 1'b1);
    check("rst_pre_triggered", triggered, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_done", done, 1'b0);
    check("rst_async_triggered", triggered, 1'b0);
    check("rst_async_rd_valid", rd_valid, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_after_busy", busy, 1'b0);

`ifdef DSO_SELF_TRIG_EN
    // ---------------- self trigger: lane0 > 200, trigin low ----------------
    // Lane values ramp to 201 and then hold, so the one-cycle-late internal
    // edge lands on a word whose lane0 is 201.
    trigin = 1'b0; trig_level = 8'd200;
    pre_len = 11'd2; post_len = 11'd2;
    datain = {16{8'd190}}; arm = 1'b1;
    step();
    arm = 1'b0;
    v = 191; idx = 0;
    while (!done && idx < 40) begin
      datain = {16{8'(v)}};
      step();
      if (v < 201) v++;
      idx++;
    end
    check("self_done", done, 1'b1);
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) check("self_first_word_lane0", rd_data[127:120], 8'd200);
      if (k == 2) check("self_trigger_word_lane0", rd_data[127:120], 8'd201);
    end
    rd_req = 1'b0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
